ov7670_frame_reader: RTL and testbench

- Sequences reads from the OV7670 module's on-board AL422B frame FIFO.
- Arms on a frame request and waits for a complete VSYNC frame. Then it pulses RRST, generates RCK, and streams exactly FRAME_BYTES bytes out on a valid/ready interface.
- RCK is throttled by downstream backpressure, so no byte is lost. It sits between the camera Pmod pins and the FPGA buffer/RPi handshake logic.

---
 rtl/ov7670_frame_reader_if.sv | 10 +
 rtl/ov7670_frame_reader.sv | 182 ++++++++++++++++++
 tb/tb_ov7670_frame_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_frame_reader_if.sv
// Pixel byte stream from the OV7670 frame reader towards the frame buffer / RPi handshake.
interface ov7670_frame_reader_if;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_last;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/ov7670_frame_reader.sv
// Reads one VSYNC-framed image out of the AL422B FIFO on the OV7670 Pmod, pacing RCK
// by downstream backpressure so that every FIFO byte is delivered exactly once.
module ov7670_frame_reader #(
   parameter int unsigned FRAME_BYTES = 38400,
   parameter int unsigned RCK_DIV     = 8,
   parameter int unsigned RRST_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         reset_p,
   input  logic                         config_done_i,
   input  logic                         frame_req_i,
   input  logic                         continuous_i,
   input  logic                         vsync_i,
   input  logic [7:0]                   d_in_i,
   output logic                         fifo_rclk_o,
   output logic                         fifo_rrst_o,
   output logic                         fifo_oe_o,
   ov7670_frame_reader_if.master        m_if,
   output logic                         busy_o,
   output logic                         frame_done_o,
   output logic                         overrun_o
);

   typedef enum logic [2:0] {IDLE, WAIT_VS_HI, WAIT_VS_LO, RRST, READ, DRAIN} state_e;

   localparam int unsigned PW = (RCK_DIV > 1) ? $clog2(RCK_DIV) : 1;
   localparam int unsigned RW = $clog2(RRST_CYCLES + 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(RCK_DIV - 1);
   localparam logic [PW-1:0] PH_HALF  = PW'(RCK_DIV / 2);
   localparam logic [RW-1:0] RR_LAST  = RW'(RRST_CYCLES - 1);
   localparam logic [18:0]   CNT_LAST = 19'(FRAME_BYTES - 1);

   state_e        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [RW-1:0] rr_cnt_q, rr_cnt_d;
   logic [18:0]   byte_cnt_q, byte_cnt_d;
   logic          pending_q, pending_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          last_q, last_d;
   logic          rclk_q, rclk_d;
   logic          rrst_n_q, rrst_n_d;
   logic          oe_n_q, oe_n_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          overrun_q, overrun_d;
   logic          vs_meta_q, vs_sync_q, vs_prev_q;
   logic          vs_rise, vs_fall, accept, rck_run;

   assign vs_rise = vs_sync_q & ~vs_prev_q;
   assign vs_fall = ~vs_sync_q & vs_prev_q;
   assign accept  = valid_q & m_if.m_ready;

   // NOTE: every signal gets a default before the case so no path leaves a latch behind.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      rr_cnt_d   = rr_cnt_q;
      byte_cnt_d = byte_cnt_q;
      pending_d  = pending_q;
      data_d     = data_q;
      valid_d    = valid_q;
      last_d     = last_q;
      overrun_d  = overrun_q;
      done_d     = 1'b0;

      if (accept) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (frame_req_i) pending_d = 1'b1;
            if (config_done_i && (pending_q || continuous_i)) begin
               state_d   = WAIT_VS_HI;
               pending_d = 1'b0;
            end
         end
         WAIT_VS_HI: if (vs_rise) state_d = WAIT_VS_LO;
         WAIT_VS_LO: begin
            if (vs_fall) begin
               state_d    = RRST;
               overrun_d  = 1'b0;
               phase_d    = '0;
               rr_cnt_d   = '0;
               byte_cnt_d = '0;
            end
         end
         RRST: begin
            if (phase_q == PH_LAST) begin
               phase_d = '0;
               if (rr_cnt_q == RR_LAST) state_d = READ;
               else                     rr_cnt_d = rr_cnt_q + 1'b1;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         READ: begin
            if (vs_rise) overrun_d = 1'b1;
            if (phase_q != PH_LAST) begin
               phase_d = phase_q + 1'b1;
            end else if (!valid_q || m_if.m_ready) begin
               // Capture on the RCK low half so d_in has settled since the rising edge.
               phase_d    = '0;
               data_d     = d_in_i;
               valid_d    = 1'b1;
               byte_cnt_d = byte_cnt_q + 1'b1;
               last_d     = (byte_cnt_q == CNT_LAST);
               if (byte_cnt_q == CNT_LAST) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (vs_rise) overrun_d = 1'b1;
            if (accept && last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Pin values follow the next state so the pins themselves come straight from flops.
      rck_run  = (state_d == RRST) || (state_d == READ);
      rclk_d   = rck_run && (phase_d < PH_HALF);
      rrst_n_d = (state_d != RRST);
      oe_n_d   = !(rck_run || (state_d == DRAIN));
      busy_d   = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         rr_cnt_q   <= '0;
         byte_cnt_q <= '0;
         pending_q  <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         rclk_q     <= 1'b0;
         rrst_n_q   <= 1'b1;
         oe_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
         vs_meta_q  <= 1'b0;
         vs_sync_q  <= 1'b0;
         vs_prev_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         rr_cnt_q   <= rr_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         pending_q  <= pending_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         rclk_q     <= rclk_d;
         rrst_n_q   <= rrst_n_d;
         oe_n_q     <= oe_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         overrun_q  <= overrun_d;
         vs_meta_q  <= vsync_i;
         vs_sync_q  <= vs_meta_q;
         vs_prev_q  <= vs_sync_q;
      end
   end

   assign fifo_rclk_o    = rclk_q;
   assign fifo_rrst_o    = rrst_n_q;
   assign fifo_oe_o      = oe_n_q;
   assign m_if.m_data    = data_q;
   assign m_if.m_valid   = valid_q;
   assign m_if.m_last    = last_q;
   assign busy_o         = busy_q;
   assign frame_done_o   = done_q;
   assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_ov7670_frame_reader.sv
// Bench for ov7670_frame_reader: an AL422B read-port model feeds random frames, and the
// accepted stream, RCK/RRST waveforms and status pins are checked against that model.
module tb_ov7670_frame_reader;

   localparam int FB          = 16;
   localparam int RCK_DIV     = 4;
   localparam int RRST_CYCLES = 2;
   localparam int MAX_CYC     = 3000;
   localparam logic [15:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

   logic       clk = 1'b0;
   logic       reset_p = 1'b1;
   logic       config_done = 1'b0;
   logic       frame_req = 1'b0;
   logic       continuous = 1'b0;
   logic       vsync = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic       fifo_rclk, fifo_rrst, fifo_oe, busy, frame_done, overrun;

   ov7670_frame_reader_if rd_if ();

   ov7670_frame_reader #(
      .FRAME_BYTES (FB),
      .RCK_DIV     (RCK_DIV),
      .RRST_CYCLES (RRST_CYCLES)
   ) dut (
      .clk           (clk),
      .reset_p       (reset_p),
      .config_done_i (config_done),
      .frame_req_i   (frame_req),
      .continuous_i  (continuous),
      .vsync_i       (vsync),
      .d_in_i        (d_in),
      .fifo_rclk_o   (fifo_rclk),
      .fifo_rrst_o   (fifo_rrst),
      .fifo_oe_o     (fifo_oe),
      .m_if          (rd_if),
      .busy_o        (busy),
      .frame_done_o  (frame_done),
      .overrun_o     (overrun)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // AL422B read port: RCK rise with RRST low resets the pointer, otherwise presents the next byte.
   logic [7:0] mem [FB];
   int         rd_ptr = 0;
   always begin
      @(posedge fifo_rclk);
      #1;
      if (!fifo_rrst) begin
         rd_ptr = 0;
         d_in   = 8'($urandom);
      end else begin
         d_in   = (rd_ptr < FB) ? mem[rd_ptr] : 8'($urandom);
         rd_ptr = rd_ptr + 1;
      end
   end

   // Observation side, sampled on the falling clock edge.
   logic [7:0] rx_data[$];
   logic       rx_last[$];
   int         rx_cyc[$];
   int cyc = 0, done_cnt = 0, read_rises = 0, all_rises = 0, pulse_err = 0;
   int hi_len = 0, lo_len = 0, rrst_pulses = 0, rrst_len = 0;
   logic rclk_prev = 1'b0, rrst_prev = 1'b1;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rd_if.m_valid && rd_if.m_ready) begin
         rx_data.push_back(rd_if.m_data);
         rx_last.push_back(rd_if.m_last);
         rx_cyc.push_back(cyc);
      end
      if (frame_done) done_cnt = done_cnt + 1;
      if (fifo_rclk && !rclk_prev) begin
         all_rises = all_rises + 1;
         if (fifo_rrst) read_rises = read_rises + 1;
      end
      if (fifo_rclk) hi_len = hi_len + 1;
      else begin
         if (rclk_prev && hi_len != RCK_DIV / 2) pulse_err = pulse_err + 1;
         hi_len = 0;
      end
      if (!fifo_rrst) lo_len = lo_len + 1;
      else begin
         if (!rrst_prev) begin
            rrst_pulses = rrst_pulses + 1;
            rrst_len    = lo_len;
         end
         lo_len = 0;
      end
      rclk_prev = fifo_rclk;
      rrst_prev = fifo_rrst;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp)
      else begin
         bad = bad + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      rx_data.delete();
      rx_last.delete();
      rx_cyc.delete();
      done_cnt    = 0;
      read_rises  = 0;
      pulse_err   = 0;
      rrst_pulses = 0;
      rrst_len    = 0;
   endtask

   function automatic logic [15:0] out_vec();
      return {fifo_rclk, fifo_rrst, fifo_oe, rd_if.m_valid, rd_if.m_last, rd_if.m_data,
              busy, frame_done, overrun};
   endfunction

   // One frame: optional request, a VSYNC pulse, random or full-rate ready, optional
   // mid-read VSYNC (ovr_at) and optional mid-frame reset (rst_at), both keyed on bytes accepted.
   task automatic do_frame(input bit req, input bit bp, input int ovr_at, input int rst_at,
                           input bit cont_off, output bit done);
      int ovr_t = 0;
      done = 1'b0;
      for (int i = 0; i < FB; i++) mem[i] = 8'($urandom);
      clear_stats();
      if (req) begin
         @(posedge clk); #1 frame_req = 1'b1;
         @(posedge clk); #1 frame_req = 1'b0;
      end
      for (int t = 0; t < MAX_CYC; t++) begin
         @(posedge clk); #1;
         vsync = (t >= 4 && t < 24);
         if (ovr_at >= 0 && (ovr_t > 0 || rx_data.size() >= ovr_at) && ovr_t < 6) begin
            vsync = 1'b1;
            ovr_t = ovr_t + 1;
         end
         rd_if.m_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
         if (cont_off && rx_data.size() > 0) continuous = 1'b0;
         if (rst_at >= 0 && rx_data.size() >= rst_at) begin
            check("rst.overrun_before", 32'(overrun), 32'd1);
            #2 reset_p = 1'b1;
            #1 check("rst.async_outputs", 32'(out_vec()), 32'(RST_VEC));
            @(posedge clk);
            @(posedge clk);
            #3 reset_p = 1'b0;
            break;
         end
         if (done_cnt > 0) begin
            done = 1'b1;
            break;
         end
      end
      vsync = 1'b0;
      rd_if.m_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input string nm, input bit done, input bit exp_busy,
                              input bit exp_ovr, input bit thr);
      check({nm, ".completed"}, 32'(done), 32'd1);
      check({nm, ".done_pulses"}, 32'(done_cnt), 32'd1);
      check({nm, ".byte_count"}, 32'(rx_data.size()), 32'(FB));
      for (int i = 0; i < rx_data.size() && i < FB; i++) begin
         check($sformatf("%s.byte%0d", nm, i), 32'(rx_data[i]), 32'(mem[i]));
         check($sformatf("%s.last%0d", nm, i), 32'(rx_last[i]), 32'(i == FB - 1));
      end
      check({nm, ".rck_rises"}, 32'(read_rises), 32'(FB));
      check({nm, ".rrst_pulses"}, 32'(rrst_pulses), 32'd1);
      check({nm, ".rrst_len"}, 32'(rrst_len), 32'(RRST_CYCLES * RCK_DIV));
      check({nm, ".rck_high_width"}, 32'(pulse_err), 32'd0);
      check({nm, ".busy"}, 32'(busy), 32'(exp_busy));
      check({nm, ".oe_n"}, 32'(fifo_oe), 32'd1);
      check({nm, ".overrun"}, 32'(overrun), 32'(exp_ovr));
      if (thr)
         for (int i = 1; i < rx_cyc.size(); i++)
            check($sformatf("%s.spacing%0d", nm, i), 32'(rx_cyc[i] - rx_cyc[i-1]), 32'(RCK_DIV));
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit d;
      int r0;
      rd_if.m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("reset.outputs", 32'(out_vec()), 32'(RST_VEC));
      #3 reset_p = 1'b0;
      config_done = 1'b1;

      do_frame(1'b1, 1'b0, -1, -1, 1'b0, d);
      check_frame("f1_basic", d, 1'b0, 1'b0, 1'b1);

      do_frame(1'b1, 1'b1, -1, -1, 1'b0, d);
      check_frame("f2_backpressure", d, 1'b0, 1'b0, 1'b0);

      do_frame(1'b1, 1'b0, 3, -1, 1'b0, d);
      check_frame("f3_overrun", d, 1'b0, 1'b1, 1'b0);

      do_frame(1'b1, 1'b0, -1, -1, 1'b0, d);
      check_frame("f4_overrun_cleared", d, 1'b0, 1'b0, 1'b0);

      // Request while unconfigured: must stay idle, then start once configuration completes.
      config_done = 1'b0;
      r0 = all_rises;
      @(posedge clk); #1 frame_req = 1'b1;
      @(posedge clk); #1 frame_req = 1'b0;
      repeat (5) @(posedge clk);
      #1 vsync = 1'b1;
      repeat (20) @(posedge clk);
      #1 vsync = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("gate.busy", 32'(busy), 32'd0);
      check("gate.rck_rises", 32'(all_rises - r0), 32'd0);
      check("gate.oe_n", 32'(fifo_oe), 32'd1);
      config_done = 1'b1;
      repeat (4) @(posedge clk);
      #1 check("gate.pending_starts", 32'(busy), 32'd1);
      do_frame(1'b0, 1'b0, -1, -1, 1'b0, d);
      check_frame("f5_pending", d, 1'b0, 1'b0, 1'b0);

      continuous = 1'b1;
      repeat (4) @(posedge clk);
      do_frame(1'b0, 1'b1, -1, -1, 1'b0, d);
      check_frame("f6_continuous", d, 1'b1, 1'b0, 1'b0);
      do_frame(1'b0, 1'b0, -1, -1, 1'b1, d);
      check_frame("f7_continuous_last", d, 1'b0, 1'b0, 1'b0);

      do_frame(1'b1, 1'b0, 3, 7, 1'b0, d);
      check("rst.aborted", 32'(d), 32'd0);
      #1 check("rst.busy_after", 32'(busy), 32'd0);

      do_frame(1'b1, 1'b0, -1, -1, 1'b0, d);
      check_frame("f9_after_reset", d, 1'b0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
